acca_mac_acc: RTL and testbench

//  Downstream accumulation stage for the 8x8 approximate multiplier (ac_* family).
//  - Consumes the 16-bit prod8 products, one per accepted beat, on a valid/ready stream.
//  - Sums each frame of products into an ACC_W-bit accumulator.
//  - Presents the frame total on a registered valid/ready output.
//  - Turns the combinational multiplier into an approximate dot-product/MAC engine.

---
 rtl/acca_mac_acc.sv | 124 ++++++++++++
 tb/tb_acca_mac_acc.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acca_mac_acc.sv
// Frame accumulator behind the prod8 approximate multiplier: sums a frame of products.
// Define ACCA_MAC_SAT_EN for saturating adds with a per-frame out_sat flag; default wraps.
module acca_mac_acc #(
   parameter int ACC_W   = 24,
   parameter int CNT_W   = 8,
   parameter int MAX_LEN = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic [ACC_W-1:0] base_acc, new_acc;
   logic [CNT_W-1:0] base_cnt, new_cnt;
   logic             accept, rel, start, close;

   assign in_ready  = ~rst & ((state_q != HOLD) | out_ready);
   assign accept    = in_valid & in_ready;
   assign rel       = (state_q == HOLD) & out_ready;
   assign out_valid = (state_q == HOLD);
   assign out_acc   = out_acc_q;
   assign out_count = out_count_q;

   // Any beat accepted outside ACCUM opens a fresh frame.
   assign start    = (state_q != ACCUM);
   assign base_acc = start ? '0 : acc_q;
   assign base_cnt = start ? '0 : cnt_q;
   assign new_cnt  = base_cnt + 1'b1;
   assign close    = in_last | (new_cnt == CNT_W'(MAX_LEN));

`ifdef ACCA_MAC_SAT_EN
   logic [ACC_W:0] sum;
   logic           sat_q, sat_d, new_sat;
   logic           out_sat_q, out_sat_d;

   always_comb begin
      sum     = {1'b0, base_acc} + (ACC_W+1)'(in_prod);
      new_acc = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      new_sat = (start ? 1'b0 : sat_q) | sum[ACC_W];
      sat_d     = sat_q;
      out_sat_d = out_sat_q;
      if (accept) begin
         sat_d = close ? 1'b0 : new_sat;
         if (close) begin
            out_sat_d = new_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q     <= 1'b0;
         out_sat_q <= 1'b0;
      end else begin
         sat_q     <= sat_d;
         out_sat_q <= out_sat_d;
      end
   end

   assign out_sat = out_sat_q;
`else
   assign new_acc = base_acc + ACC_W'(in_prod);
   assign out_sat = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_acc_d   = out_acc_q;
      out_count_d = out_count_q;
      if (accept) begin
         if (close) begin
            state_d     = HOLD;
            acc_d       = '0;
            cnt_d       = '0;
            out_acc_d   = new_acc;
            out_count_d = new_cnt;
         end else begin
            state_d = ACCUM;
            acc_d   = new_acc;
            cnt_d   = new_cnt;
         end
      end else if (rel) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_acc_q   <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_acc_q   <= out_acc_d;
         out_count_q <= out_count_d;
      end
   end

endmodule

// File: tb/tb_acca_mac_acc.sv
// Directed bench for acca_mac_acc: default 24-bit instance plus a 16-bit overflow instance.
module tb_acca_mac_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_prod = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] out_acc;
   logic [7:0]  out_count;
   logic        out_sat;

   logic        v16 = 1'b0;
   logic        rdy16;
   logic [15:0] p16 = '0;
   logic        l16 = 1'b0;
   logic        ov16;
   logic        ordy16 = 1'b0;
   logic [15:0] acc16;
   logic [7:0]  cnt16;
   logic        sat16;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   acca_mac_acc dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_prod(in_prod), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_count(out_count), .out_sat(out_sat)
   );

   acca_mac_acc #(.ACC_W(16)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(v16), .in_ready(rdy16),
      .in_prod(p16), .in_last(l16),
      .out_valid(ov16), .out_ready(ordy16),
      .out_acc(acc16), .out_count(cnt16), .out_sat(sat16)
   );

   // Presents one beat and waits (bounded) until it is accepted.
   task automatic send(input logic [15:0] p, input logic l);
      bit ok = 0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_in_ready: got %b required 0", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0 || out_acc !== 24'h0 || out_count !== 8'h0 || out_sat !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: v=%b acc=%h cnt=%h sat=%b required 0/0/0/0",
                  out_valid, out_acc, out_count, out_sat);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_after: got %b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      send(16'h0100, 1'b0);
      send(16'h0200, 1'b0);
      send(16'h0300, 1'b0);
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_early_valid: got %b required 0", out_valid);
      end
      send(16'h0400, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_acc !== 24'h000A00 || out_count !== 8'd4 || out_sat !== 1'b0) begin
         fails++;
         $display("FAIL basic_result: v=%b acc=%h cnt=%0d sat=%b required 1/000a00/4/0",
                  out_valid, out_acc, out_count, out_sat);
      end
      release_out();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_release: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_single();
      send(16'h1234, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_acc !== 24'h001234 || out_count !== 8'd1) begin
         fails++;
         $display("FAIL single_result: v=%b acc=%h cnt=%0d required 1/001234/1",
                  out_valid, out_acc, out_count);
      end
      release_out();
   endtask

   task automatic test_autoclose();
      for (int i = 0; i < 255; i++) begin
         send(16'hFFFF, 1'b0);
      end
      tests++;
      if (out_valid !== 1'b1 || out_acc !== 24'hFEFF01 || out_count !== 8'd255) begin
         fails++;
         $display("FAIL autoclose_result: v=%b acc=%h cnt=%0d required 1/feff01/255",
                  out_valid, out_acc, out_count);
      end
      in_valid = 1'b1;
      in_prod  = 16'hFFFF;
      in_last  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL autoclose_stall: in_ready=%b out_valid=%b required 0/1", in_ready, out_valid);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL autoclose_turnover: out_valid=%b required 0", out_valid);
      end
      send(16'h0001, 1'b1);
      tests++;
      if (out_acc !== 24'h010000 || out_count !== 8'd2) begin
         fails++;
         $display("FAIL autoclose_next: acc=%h cnt=%0d required 010000/2", out_acc, out_count);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      send(16'h0010, 1'b0);
      send(16'h0020, 1'b1);
      in_valid = 1'b1;
      in_prod  = 16'h0005;
      in_last  = 1'b0;
      repeat (5) begin
         @(negedge clk);
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 24'h000030 || out_count !== 8'd2) begin
            fails++;
            $display("FAIL bp_hold: rdy=%b v=%b acc=%h cnt=%0d required 0/1/000030/2",
                     in_ready, out_valid, out_acc, out_count);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: out_valid=%b required 0", out_valid);
      end
      send(16'h0003, 1'b1);
      tests++;
      if (out_acc !== 24'h000008 || out_count !== 8'd2) begin
         fails++;
         $display("FAIL bp_next_frame: acc=%h cnt=%0d required 000008/2", out_acc, out_count);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      send(16'h0011, 1'b1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_prod   = 16'h0022;
      in_last   = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      tests++;
      if (out_valid !== 1'b1 || out_acc !== 24'h000022 || out_count !== 8'd1) begin
         fails++;
         $display("FAIL b2b_result: v=%b acc=%h cnt=%0d required 1/000022/1",
                  out_valid, out_acc, out_count);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      send(16'h0100, 1'b0);
      send(16'h0200, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || out_count !== 8'd0) begin
         fails++;
         $display("FAIL rstmid_clear: v=%b cnt=%0d required 0/0", out_valid, out_count);
      end
      send(16'h0007, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_acc !== 24'h000007 || out_count !== 8'd1) begin
         fails++;
         $display("FAIL rstmid_result: v=%b acc=%h cnt=%0d required 1/000007/1",
                  out_valid, out_acc, out_count);
      end
      release_out();
   endtask

   task automatic test_overflow();
      logic [15:0] exp_acc;
      logic        exp_sat;
`ifdef ACCA_MAC_SAT_EN
      exp_acc = 16'hFFFF;
      exp_sat = 1'b1;
`else
      exp_acc = 16'h0001;
      exp_sat = 1'b0;
`endif
      tests++;
      if (rdy16 !== 1'b1) begin
         fails++;
         $display("FAIL ovf_ready: got %b required 1", rdy16);
      end
      v16 = 1'b1;
      p16 = 16'hFFFF;
      l16 = 1'b0;
      @(posedge clk);
      #1;
      p16 = 16'h0002;
      l16 = 1'b1;
      @(posedge clk);
      #1;
      v16 = 1'b0;
      l16 = 1'b0;
      tests++;
      if (ov16 !== 1'b1 || acc16 !== exp_acc || sat16 !== exp_sat || cnt16 !== 8'd2) begin
         fails++;
         $display("FAIL ovf_result: v=%b acc=%h sat=%b cnt=%0d required 1/%h/%b/2",
                  ov16, acc16, sat16, cnt16, exp_acc, exp_sat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_autoclose();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
